// File: rtl/aes_block_serializer_pkg.sv
// Shared types and sizing helpers for the AES block serializer.
package aes_ser_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BUS_W   = 32;

    typedef enum logic {
        SER_IDLE,
        SER_SHIFT
    } ser_state_t;

    function automatic int nwords(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

endpackage

// File: rtl/aes_block_serializer_if.sv
// Block-in / word-out stream bundle. master = the serializer, slave = its environment.
interface aes_block_serializer_if
    import aes_ser_pkg::*;
#(
    parameter int IN_W  = AES_BLOCK_W,
    parameter int OUT_W = AES_BUS_W
);
    localparam int IDX_W = $clog2(nwords(IN_W, OUT_W));

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic [IDX_W-1:0]  out_idx;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_idx
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_idx
    );

endinterface

// File: rtl/aes_block_serializer.sv
// Width down-converter: takes one IN_W block and emits IN_W/OUT_W words with
// valid/ready on both sides, word index, last flag and bubble-free block chaining.
module aes_block_serializer
    import aes_ser_pkg::*;
#(
    parameter int IN_W      = AES_BLOCK_W,
    parameter int OUT_W     = AES_BUS_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    aes_block_serializer_if.master bus,
    output logic                   busy
);

    localparam int NWORDS = nwords(IN_W, OUT_W);
    localparam int CNT_W  = $clog2(NWORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    if ((IN_W % OUT_W) != 0 || NWORDS < 2) begin : g_bad_params
        $error("aes_block_serializer: IN_W must be a multiple of OUT_W giving at least two words");
    end

    ser_state_t       state, state_nxt;
    logic [IN_W-1:0]  sreg, sreg_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             last;
    logic [OUT_W-1:0] word;

    assign last = (cnt == LAST_IDX);
    assign word = MSB_FIRST ? sreg[IN_W-1 -: OUT_W] : sreg[OUT_W-1:0];
    assign busy = (state == SER_SHIFT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the shift register is reset too (not left as don't-care storage),
    // so a mid-block reset discards the held block completely.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SER_IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        sreg_nxt      = sreg;
        cnt_nxt       = cnt;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        bus.out_idx   = '0;

        unique case (state)
            SER_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = SER_SHIFT;
                    sreg_nxt  = bus.in_data;
                    cnt_nxt   = '0;
                end
            end

            SER_SHIFT: begin
                bus.out_valid = 1'b1;
                bus.out_data  = word;
                bus.out_last  = last;
                bus.out_idx   = cnt;
                if (bus.out_ready) begin
                    if (last) begin
                        // Final word leaving: chain straight into the next block if one waits.
                        bus.in_ready = 1'b1;
                        if (bus.in_valid) begin
                            sreg_nxt = bus.in_data;
                            cnt_nxt  = '0;
                        end else begin
                            state_nxt = SER_IDLE;
                            sreg_nxt  = '0;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        sreg_nxt = MSB_FIRST ? (sreg << OUT_W) : (sreg >> OUT_W);
                        cnt_nxt  = cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = SER_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed bench: a per-cycle stimulus/expectation table for the 128/32 MSB-first
// instance, plus short sequences for LSB-first and the 64/16 and 96/32 variants.
module tb_aes_block_serializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy0, busy1, busy2, busy3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aes_block_serializer_if #(.IN_W(128), .OUT_W(32)) if0();
    aes_block_serializer_if #(.IN_W(128), .OUT_W(32)) if1();
    aes_block_serializer_if #(.IN_W(64),  .OUT_W(16)) if2();
    aes_block_serializer_if #(.IN_W(96),  .OUT_W(32)) if3();

    aes_block_serializer #(.IN_W(128), .OUT_W(32), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .reset(reset), .bus(if0.master), .busy(busy0));
    aes_block_serializer #(.IN_W(128), .OUT_W(32), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .reset(reset), .bus(if1.master), .busy(busy1));
    aes_block_serializer #(.IN_W(64), .OUT_W(16), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .reset(reset), .bus(if2.master), .busy(busy2));
    aes_block_serializer #(.IN_W(96), .OUT_W(32), .MSB_FIRST(1'b1)) u3 (
        .clk(clk), .reset(reset), .bus(if3.master), .busy(busy3));

    typedef struct packed {
        logic         rst;
        logic         iv;
        logic [127:0] din;
        logic         ordy;
        logic         ev;
        logic [31:0]  ed;
        logic [1:0]   ei;
        logic         el;
        logic         eir;
        logic         eb;
    } step_t;

    step_t steps[$];

    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    logic [31:0] exp1 [4];
    logic [15:0] exp2 [4];
    logic [31:0] exp3 [3];

    function automatic step_t stp(input logic rst, input logic iv, input logic [127:0] din,
                                  input logic ordy, input logic ev, input logic [31:0] ed,
                                  input logic [1:0] ei, input logic el, input logic eir,
                                  input logic eb);
        step_t s;
        s.rst = rst; s.iv = iv; s.din = din; s.ordy = ordy;
        s.ev = ev; s.ed = ed; s.ei = ei; s.el = el; s.eir = eir; s.eb = eb;
        return s;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b0;
        if3.in_valid = 1'b0; if3.in_data = '0; if3.out_ready = 1'b0;

        exp1 = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
        exp2 = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        exp3 = '{32'h11111111, 32'h22222222, 32'h33333333};

        // rst iv  din    rdy  ev  data          idx last in_rdy busy
        // single block, free-flowing output, then idle
        steps.push_back(stp(0, 1, BLK_A, 1, 0, 32'h0,        0, 0, 1, 0));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'h00112233, 0, 0, 0, 1));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'h44556677, 1, 0, 0, 1));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'h8899AABB, 2, 0, 0, 1));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'hCCDDEEFF, 3, 1, 1, 1));
        steps.push_back(stp(0, 0, '0,    1, 0, 32'h0,        0, 0, 1, 0));
        // backpressure; stray in_valid during the block must be ignored
        steps.push_back(stp(0, 1, BLK_A, 0, 0, 32'h0,        0, 0, 1, 0));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'h00112233, 0, 0, 0, 1));
        steps.push_back(stp(0, 0, '0,    0, 1, 32'h44556677, 1, 0, 0, 1));
        steps.push_back(stp(0, 1, BLK_B, 0, 1, 32'h44556677, 1, 0, 0, 1));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'h44556677, 1, 0, 0, 1));
        steps.push_back(stp(0, 0, '0,    0, 1, 32'h8899AABB, 2, 0, 0, 1));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'h8899AABB, 2, 0, 0, 1));
        steps.push_back(stp(0, 1, BLK_B, 0, 1, 32'hCCDDEEFF, 3, 1, 0, 1));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'hCCDDEEFF, 3, 1, 1, 1));
        steps.push_back(stp(0, 0, '0,    1, 0, 32'h0,        0, 0, 1, 0));
        // back-to-back: B offered on A's last-word handshake, no bubble
        steps.push_back(stp(0, 1, BLK_A, 1, 0, 32'h0,        0, 0, 1, 0));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'h00112233, 0, 0, 0, 1));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'h44556677, 1, 0, 0, 1));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'h8899AABB, 2, 0, 0, 1));
        steps.push_back(stp(0, 1, BLK_B, 1, 1, 32'hCCDDEEFF, 3, 1, 1, 1));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'hDEADBEEF, 0, 0, 0, 1));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'h01234567, 1, 0, 0, 1));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'h89ABCDEF, 2, 0, 0, 1));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'hCAFEF00D, 3, 1, 1, 1));
        steps.push_back(stp(0, 0, '0,    1, 0, 32'h0,        0, 0, 1, 0));
        // reset after word 1, then a fresh block restarts at index 0
        steps.push_back(stp(0, 1, BLK_A, 1, 0, 32'h0,        0, 0, 1, 0));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'h00112233, 0, 0, 0, 1));
        steps.push_back(stp(1, 0, '0,    0, 1, 32'h44556677, 1, 0, 0, 1));
        steps.push_back(stp(0, 1, BLK_B, 1, 0, 32'h0,        0, 0, 1, 0));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'hDEADBEEF, 0, 0, 0, 1));
        steps.push_back(stp(0, 0, '0,    1, 1, 32'h01234567, 1, 0, 0, 1));

        tick();
        tick();

        foreach (steps[i]) begin
            reset         = steps[i].rst;
            if0.in_valid  = steps[i].iv;
            if0.in_data   = steps[i].din;
            if0.out_ready = steps[i].ordy;
            @(negedge clk);
            check($sformatf("s%0d.out_valid", i), if0.out_valid, steps[i].ev);
            check($sformatf("s%0d.out_data", i),  if0.out_data,  steps[i].ed);
            check($sformatf("s%0d.out_idx", i),   if0.out_idx,   steps[i].ei);
            check($sformatf("s%0d.out_last", i),  if0.out_last,  steps[i].el);
            check($sformatf("s%0d.in_ready", i),  if0.in_ready,  steps[i].eir);
            check($sformatf("s%0d.busy", i),      busy0,         steps[i].eb);
            tick();
        end
        reset         = 1'b0;
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b0;

        // LSB-first order on the same block
        if1.in_data = BLK_A; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
        tick();
        if1.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("lsb%0d.out_valid", i), if1.out_valid, 1'b1);
            check($sformatf("lsb%0d.out_data", i),  if1.out_data,  exp1[i]);
            check($sformatf("lsb%0d.out_idx", i),   if1.out_idx,   i);
            check($sformatf("lsb%0d.out_last", i),  if1.out_last,  (i == 3));
            tick();
        end
        @(negedge clk);
        check("lsb.idle_valid", if1.out_valid, 1'b0);
        check("lsb.idle_busy", busy1, 1'b0);

        // 64/16 variant
        if2.in_data = 64'h0123_4567_89AB_CDEF; if2.in_valid = 1'b1; if2.out_ready = 1'b1;
        tick();
        if2.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("w16_%0d.out_data", i), if2.out_data, exp2[i]);
            check($sformatf("w16_%0d.out_idx", i),  if2.out_idx,  i);
            check($sformatf("w16_%0d.out_last", i), if2.out_last, (i == 3));
            tick();
        end
        @(negedge clk);
        check("w16.idle_valid", if2.out_valid, 1'b0);

        // 96/32 variant: three words, last on index 2
        if3.in_data = 96'h11111111_22222222_33333333; if3.in_valid = 1'b1; if3.out_ready = 1'b1;
        tick();
        if3.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("w96_%0d.out_valid", i), if3.out_valid, 1'b1);
            check($sformatf("w96_%0d.out_data", i),  if3.out_data,  exp3[i]);
            check($sformatf("w96_%0d.out_idx", i),   if3.out_idx,   i);
            check($sformatf("w96_%0d.out_last", i),  if3.out_last,  (i == 2));
            tick();
        end
        @(negedge clk);
        check("w96.idle_valid", if3.out_valid, 1'b0);
        check("w96.idle_in_ready", if3.in_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
